// File: rtl/phys_mem_ctrl.sv
// Physical-side memory controller: async SRAM with programmable wait states plus a req/ack peripheral port.
// Optional peripheral timeout is enabled by defining PHYS_MEM_PERIPH_TIMEOUT_EN.
module phys_mem_ctrl #(
    parameter int SRAM_AW        = 20,
    parameter int SRAM_RD_WAIT   = 2,
    parameter int SRAM_WR_WAIT   = 2,
    parameter int PERIPH_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic                mem_is_write,
    output logic [31:0]         mem_rdata,
    output logic                mem_busy,
    output logic                mem_bus_err,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [31:0]         sram_dq_o,
    input  logic [31:0]         sram_dq_i,
    output logic                sram_dq_oe,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                periph_req,
    output logic                periph_we,
    output logic [31:0]         periph_addr,
    output logic [31:0]         periph_wdata,
    input  logic [31:0]         periph_rdata,
    input  logic                periph_ack
);

    localparam int WAIT_MAX = (SRAM_RD_WAIT > SRAM_WR_WAIT) ? SRAM_RD_WAIT : SRAM_WR_WAIT;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, PERIPH
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        addr_reg, wdata_reg, rdata_reg;
    logic               we_reg;
    logic [29:0]        last_addr_reg;
    logic               last_valid_reg;
    logic               ce_n_reg, oe_n_reg, we_n_reg, dq_oe_reg, req_reg;

    logic               start, launch, is_sram;
    logic               rd_done, periph_done, timeout;

    // No launch while reset is held, so busy stays low during reset.
    assign start   = rst && (mem_is_write || !last_valid_reg || (mem_addr[31:2] != last_addr_reg));
    assign launch  = (state_reg == IDLE) && start;
    assign is_sram = (mem_addr[31:SRAM_AW+2] == '0);

`ifdef PHYS_MEM_PERIPH_TIMEOUT_EN
    localparam int TO_W = $clog2(PERIPH_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;

    // Ack on the final cycle takes priority over the timeout.
    assign timeout = (state_reg == PERIPH) && !periph_ack &&
                     (to_cnt_reg == TO_W'(PERIPH_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            err_reg <= timeout;
            if (state_reg == PERIPH)
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            else
                to_cnt_reg <= '0;
        end
    end

    assign mem_bus_err = err_reg;
`else
    assign timeout     = 1'b0;
    assign mem_bus_err = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rd_done     = 1'b0;
        periph_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    cnt_next = '0;
                    if (!is_sram)
                        state_next = PERIPH;
                    else if (mem_is_write)
                        state_next = WR_SETUP;
                    else
                        state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_reg == CNT_W'(SRAM_RD_WAIT - 1)) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR_SETUP: begin
                cnt_next   = '0;
                state_next = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_reg == CNT_W'(SRAM_WR_WAIT - 1))
                    state_next = WR_HOLD;
                else
                    cnt_next = cnt_reg + CNT_W'(1);
            end
            WR_HOLD: state_next = IDLE;
            PERIPH: begin
                if (periph_ack) begin
                    periph_done = 1'b1;
                    state_next  = IDLE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the async SRAM sees glitch-free edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            last_addr_reg  <= '0;
            last_valid_reg <= 1'b0;
            rdata_reg      <= '0;
            ce_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            dq_oe_reg      <= 1'b0;
            req_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ce_n_reg  <= !(state_next inside {RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD});
            oe_n_reg  <= (state_next != RD_WAIT);
            we_n_reg  <= (state_next != WR_PULSE);
            dq_oe_reg <= (state_next inside {WR_SETUP, WR_PULSE, WR_HOLD});
            req_reg   <= (state_next == PERIPH);
            if (launch) begin
                addr_reg       <= mem_addr;
                wdata_reg      <= mem_wdata;
                we_reg         <= mem_is_write;
                last_addr_reg  <= mem_addr[31:2];
                last_valid_reg <= 1'b0;
            end
            if (rd_done) begin
                rdata_reg      <= sram_dq_i;
                last_valid_reg <= 1'b1;
            end
            if (periph_done && !we_reg)
                rdata_reg <= periph_rdata;
            if (timeout)
                rdata_reg <= 32'hFFFF_FFFF;
        end
    end

    assign mem_busy     = (state_reg != IDLE) || start;
    assign mem_rdata    = rdata_reg;
    assign sram_addr    = addr_reg[SRAM_AW+1:2];
    assign sram_dq_o    = wdata_reg;
    assign sram_dq_oe   = dq_oe_reg;
    assign sram_ce_n    = ce_n_reg;
    assign sram_oe_n    = oe_n_reg;
    assign sram_we_n    = we_n_reg;
    assign periph_req   = req_reg;
    assign periph_we    = we_reg;
    assign periph_addr  = addr_reg;
    assign periph_wdata = wdata_reg;

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Self-checking bench for phys_mem_ctrl: vector table with an expected-read-data scoreboard,
// plus hand sequences for peripheral timeout/hang and reset during a write pulse.
module tb_phys_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_is_write, mem_busy, mem_bus_err;
    logic [19:0] sram_addr;
    logic [31:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic        periph_req, periph_we, periph_ack;
    logic [31:0] periph_addr, periph_wdata, periph_rdata;

    phys_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_is_write(mem_is_write),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_bus_err(mem_bus_err),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .periph_req(periph_req), .periph_we(periph_we), .periph_addr(periph_addr),
        .periph_wdata(periph_wdata), .periph_rdata(periph_rdata), .periph_ack(periph_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] d;      // sram_dq_i / periph_rdata supplied
        int          ack;    // ack on this peripheral req cycle
        logic        l;      // launch expected
        int          ce, oe, wel, dqoe, req;
        logic [31:0] er;     // mem_rdata after access
        logic [31:0] sa;     // expected SRAM word address
        logic        idle;   // busy must be low right after completion
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    vec_t        vt[14];

    function automatic vec_t mk(logic [31:0] a, logic [31:0] wd, logic w, logic [31:0] d, int ack,
                                logic l, int ce, int oe, int wel, int dqoe, int req,
                                logic [31:0] er, logic [31:0] sa, logic idle);
        vec_t v;
        v.addr = a; v.wdata = wd; v.we = w; v.d = d; v.ack = ack; v.l = l;
        v.ce = ce; v.oe = oe; v.wel = wel; v.dqoe = dqoe; v.req = req;
        v.er = er; v.sa = sa; v.idle = idle;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ce_n"}, sram_ce_n, 1);
        chk({tag, "_oe_n"}, sram_oe_n, 1);
        chk({tag, "_we_n"}, sram_we_n, 1);
        chk({tag, "_dq_oe"}, sram_dq_oe, 0);
        chk({tag, "_req"}, periph_req, 0);
        chk({tag, "_rdata"}, mem_rdata, 0);
        chk({tag, "_busy"}, mem_busy, 0);
        chk({tag, "_err"}, mem_bus_err, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   ce_c, oe_c, we_c, dq_c, rq_c, c;
        logic proto, addr_bad, quiet_bad, first, done, found;

        //        addr          wdata         we d             ack l  ce oe we dq rq er            sa        idle
        vt[0]  = mk(32'h10,       0,           0, 32'hDEADBEEF, 0,  1, 2, 2, 0, 0, 0, 32'hDEADBEEF, 32'h4,     1);
        vt[1]  = mk(32'h10,       0,           0, 32'h0,        0,  0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h4,     1);
        vt[2]  = mk(32'h20, 32'h12345678,      1, 32'h0,        0,  1, 4, 0, 2, 4, 0, 32'hDEADBEEF, 32'h8,     0);
        vt[3]  = mk(32'h20,       0,           0, 32'hCAFEF00D, 0,  1, 2, 2, 0, 0, 0, 32'hCAFEF00D, 32'h8,     1);
        vt[4]  = mk(32'h1FD003F8, 0,           0, 32'h41,       5,  1, 0, 0, 0, 0, 5, 32'h41,       0,         0);
        vt[5]  = mk(32'h1FD003F8, 0,           0, 32'h77,       2,  1, 0, 0, 0, 0, 2, 32'h77,       0,         0);
        vt[6]  = mk(32'h80000000, 32'h55,      1, 32'h0,        3,  1, 0, 0, 0, 0, 3, 32'h77,       0,         0);
        vt[7]  = mk(32'h3FFFFC,   0,           0, 32'hA5A55A5A, 0,  1, 2, 2, 0, 0, 0, 32'hA5A55A5A, 32'hFFFFF, 1);
        vt[8]  = mk(32'h400000,   0,           0, 32'h99,       1,  1, 0, 0, 0, 0, 1, 32'h99,       0,         0);
        vt[9]  = mk(32'h3FFFFC,   0,           0, 32'h0BADF00D, 0,  1, 2, 2, 0, 0, 0, 32'h0BADF00D, 32'hFFFFF, 1);
        vt[10] = mk(32'h3FFFFC,   0,           0, 32'h0,        0,  0, 0, 0, 0, 0, 0, 32'h0BADF00D, 32'hFFFFF, 1);
        vt[11] = mk(32'h3FFFFC,   32'h1,       1, 32'h0,        0,  1, 4, 0, 2, 4, 0, 32'h0BADF00D, 32'hFFFFF, 0);
        vt[12] = mk(32'h3FFFFC,   0,           0, 32'h2,        0,  1, 2, 2, 0, 0, 0, 32'h2,        32'hFFFFF, 1);
        vt[13] = mk(32'hFFFFFFFC, 0,           0, 32'h1234,   255,  1, 0, 0, 0, 0, 255, 32'h1234,   0,         0);

        rst = 1'b0; mem_addr = '0; mem_wdata = '0; mem_is_write = 1'b0;
        sram_dq_i = '0; periph_rdata = '0; periph_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("reset");

        for (int i = 0; i < 14; i++) begin
            v = vt[i];
            rst = 1'b1;
            mem_addr = v.addr; mem_wdata = v.wdata; mem_is_write = v.we;
            sram_dq_i = v.d; periph_rdata = v.d;
            #1;
            chk("launch", mem_busy, v.l);
            exp_q.push_back(v.er);
            ce_c = 0; oe_c = 0; we_c = 0; dq_c = 0; rq_c = 0;
            proto = 0; addr_bad = 0; quiet_bad = 0; first = 1; done = 0;
            if (v.l) begin
                for (c = 0; c < 600 && !done; c++) begin
                    @(posedge clk); #1;
                    mem_is_write = 1'b0; periph_ack = 1'b0;
                    @(negedge clk);
                    if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n)) proto = 1;
                    if (!sram_ce_n || periph_req) begin
                        if (first) begin
                            if (v.ce > 0)
                                addr_bad = ({12'b0, sram_addr} != v.sa) || (v.we && sram_dq_o != v.wdata);
                            else
                                addr_bad = (periph_we != v.we) || (v.we && periph_wdata != v.wdata);
                        end
                        first = 0;
                        if (periph_req && periph_addr != v.addr) addr_bad = 1;
                        if (!sram_ce_n) ce_c++;
                        if (!sram_oe_n) oe_c++;
                        if (!sram_we_n) we_c++;
                        if (sram_dq_oe) dq_c++;
                        if (periph_req) begin
                            rq_c++;
                            if (rq_c == v.ack) periph_ack = 1'b1;
                        end
                    end else if (!first) begin
                        done = 1;
                    end
                end
                chk("complete", done, 1);
                if (v.idle) chk("idle_after", mem_busy, 0);
            end else begin
                for (c = 0; c < 10; c++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    if (mem_busy || !sram_ce_n || periph_req) quiet_bad = 1;
                end
                chk("quiet", quiet_bad, 0);
            end
            chk("ce_cycles", ce_c, v.ce);
            chk("oe_cycles", oe_c, v.oe);
            chk("we_cycles", we_c, v.wel);
            chk("dq_oe_cycles", dq_c, v.dqoe);
            chk("req_cycles", rq_c, v.req);
            chk("addr_data", addr_bad, 0);
            chk("protocol", proto, 0);
            chk("rdata", mem_rdata, exp_q.pop_front());
            $display("vec %0d addr=%h we=%0d ce=%0d req=%0d rdata=%h", i, v.addr, v.we, ce_c, rq_c, mem_rdata);
        end

        // Peripheral read that is never acknowledged.
        mem_addr = 32'h40000000; mem_is_write = 1'b0; periph_rdata = 32'hEE;
        #1;
        chk("noack_launch", mem_busy, 1);
        rq_c = 0; done = 0;
`ifdef PHYS_MEM_PERIPH_TIMEOUT_EN
        for (c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (periph_req) rq_c++;
            else done = 1;
        end
        chk("to_req_cycles", rq_c, 255);
        chk("to_rdata", mem_rdata, 32'hFFFFFFFF);
        chk("to_err", mem_bus_err, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_err_clear", mem_bus_err, 0);
        $display("timeout seq req=%0d rdata=%h", rq_c, mem_rdata);
`else
        for (c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (periph_req) rq_c++;
        end
        chk("hang_req", rq_c, 300);
        chk("hang_busy", mem_busy, 1);
        chk("hang_err", mem_bus_err, 0);
        $display("hang seq req=%0d busy=%0d", rq_c, mem_busy);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset_check("reset2");

        // Reset asserted during the write pulse abandons the access.
        rst = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hAB; mem_is_write = 1'b1;
        #1;
        chk("wr_launch", mem_busy, 1);
        @(posedge clk); #1;
        mem_is_write = 1'b0;
        found = 0;
        for (c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (!sram_we_n) found = 1;
        end
        chk("wr_pulse_seen", found, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset_check("midwrite");
        $display("reset mid-pulse we_n=%0d dq_oe=%0d busy=%0d", sram_we_n, sram_dq_oe, mem_busy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
